// File: rtl/fir_pkg.sv
// Shared defaults, FSM state type and rounding helper for the FIR result writer.
package fir_pkg;

  localparam int IN_W_DEF   = 93;
  localparam int OUT_W_DEF  = 16;
  localparam int ADDR_W_DEF = 11;
  localparam int RC_W       = 256;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN
  } state_t;

  // Half an output LSB at the input scale: 2^(shift-1).
  function automatic logic [RC_W-1:0] round_const(input int shift);
    return RC_W'(1) << (shift - 1);
  endfunction

endpackage

// File: rtl/fir_round_sat.sv
// Two-stage rescaler: round-half-up + arithmetic shift, then saturate to OUT_W.
module fir_round_sat
  import fir_pkg::*;
#(
  parameter int IN_W  = IN_W_DEF,
  parameter int OUT_W = OUT_W_DEF,
  parameter int SHIFT = 20
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [IN_W-1:0]  in_data,
  output logic             out_valid,
  output logic [OUT_W-1:0] out_data,
  output logic             out_sat
);

  localparam int SH_W = IN_W + 1 - SHIFT;
  localparam logic [IN_W:0] RND = (IN_W + 1)'(round_const(SHIFT));
  localparam logic [OUT_W-1:0] OUT_MAX = {1'b0, {(OUT_W - 1){1'b1}}};
  localparam logic [OUT_W-1:0] OUT_MIN = {1'b1, {(OUT_W - 1){1'b0}}};

  // One guard bit above the sign keeps the rounding add from overflowing.
  logic [IN_W:0]    sum;
  logic [SHIFT-1:0] frac_unused;
  logic             s1_valid;
  logic [SH_W-1:0]  s1_q;
  logic             ovf;
  logic [OUT_W-1:0] clamp;

  assign sum         = {in_data[IN_W-1], in_data} + RND;
  assign frac_unused = sum[SHIFT-1:0];

  always_ff @(posedge clk) begin
    if (!rst) begin
      s1_valid <= 1'b0;
    end else begin
      s1_valid <= in_valid;
    end
  end

  // NOTE: pure datapath registers need no reset; only the valid bits qualify them.
  always_ff @(posedge clk) begin
    if (in_valid) begin
      s1_q <= sum[IN_W:SHIFT];
    end
  end

  generate
    if (SH_W > OUT_W) begin : g_clip
      logic [SH_W-OUT_W:0] top;
      assign top   = s1_q[SH_W-1:OUT_W-1];
      assign ovf   = !((&top) || !(|top));
      assign clamp = ovf ? (s1_q[SH_W-1] ? OUT_MIN : OUT_MAX) : s1_q[OUT_W-1:0];
    end else begin : g_ext
      assign ovf   = 1'b0;
      assign clamp = OUT_W'($signed(s1_q));
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (!rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_sat   <= 1'b0;
    end else begin
      out_valid <= s1_valid;
      out_sat   <= s1_valid & ovf;
      if (s1_valid) begin
        out_data <= clamp;
      end
    end
  end

endmodule

// File: rtl/fir_result_writer.sv
// Frame controller: accepts FRAME_LEN filter samples, writes rescaled results to RAM.
module fir_result_writer
  import fir_pkg::*;
#(
  parameter int IN_W      = IN_W_DEF,
  parameter int OUT_W     = OUT_W_DEF,
  parameter int SHIFT     = 20,
  parameter int ADDR_W    = ADDR_W_DEF,
  parameter int FRAME_LEN = 2048
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [IN_W-1:0]   in_data,
  input  logic              in_valid,
  input  logic [1:0]        in_error,
  output logic [ADDR_W-1:0] ram_address,
  output logic [OUT_W-1:0]  ram_data,
  output logic              ram_wren,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W:0]   sat_count,
  output logic              err_seen
);

  localparam int CNT_W = ADDR_W + 1;
  localparam logic [CNT_W-1:0] LAST    = CNT_W'(FRAME_LEN - 1);
  localparam logic [CNT_W-1:0] SAT_MAX = '1;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] acc_cnt;
  logic [CNT_W-1:0] wr_cnt;
  logic             arm, accept, last_acc, last_wr;
  logic             pipe_valid, pipe_sat;
  logic [OUT_W-1:0] pipe_data;

  assign arm      = (state == IDLE) && start;
  assign accept   = (state == RUN) && in_valid;
  assign last_acc = accept && (acc_cnt == LAST);
  assign last_wr  = pipe_valid && (wr_cnt == LAST);

  fir_round_sat #(
    .IN_W (IN_W),
    .OUT_W(OUT_W),
    .SHIFT(SHIFT)
  ) u_round_sat (
    .clk      (clk),
    .rst      (rst),
    .in_valid (accept),
    .in_data  (in_data),
    .out_valid(pipe_valid),
    .out_data (pipe_data),
    .out_sat  (pipe_sat)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    case (state)
      IDLE:    if (start) state_nxt = RUN;
      RUN:     if (last_acc) state_nxt = DRAIN;
      DRAIN:   if (last_wr) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    busy = (state != IDLE);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      acc_cnt   <= '0;
      wr_cnt    <= '0;
      sat_count <= '0;
      err_seen  <= 1'b0;
    end else if (arm) begin
      acc_cnt   <= '0;
      wr_cnt    <= '0;
      sat_count <= '0;
      err_seen  <= 1'b0;
    end else begin
      if (accept) begin
        acc_cnt <= acc_cnt + 1'b1;
      end
      if (accept && (in_error != 2'b00)) begin
        err_seen <= 1'b1;
      end
      if (pipe_valid) begin
        wr_cnt <= last_wr ? '0 : wr_cnt + 1'b1;
      end
      if (pipe_valid && pipe_sat && (sat_count != SAT_MAX)) begin
        sat_count <= sat_count + 1'b1;
      end
    end
  end

  // Gating with rst suppresses a write that would otherwise land in the reset cycle.
  assign ram_wren    = pipe_valid & rst;
  assign done        = last_wr & rst;
  assign ram_data    = pipe_data;
  assign ram_address = wr_cnt[ADDR_W-1:0];

endmodule
